bcd6_to_bin: RTL and testbench

- Iterative converter that reads the 24-bit packed BCD count produced by the team's 6-digit decimal counters and returns its binary value.
- Feeds downstream arithmetic (rate/period math, compare thresholds) that cannot consume BCD.
- Processes one BCD digit per clock, most-significant digit first; start/busy/done handshake.

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_mac10.sv | 19 +
 rtl/bcd6_to_bin.sv | 151 +++++++++++++++
 tb/tb_bcd6_to_bin.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and sizing helper for the BCD-to-binary converter.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_DIGIT_MAX = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    // Smallest width w with 2^w > 10^digits - 1.
    function automatic int min_bin_w(input int digits);
        longint unsigned max_v;
        int w;
        max_v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            max_v = max_v * 64'd10;
        end
        max_v = max_v - 64'd1;
        w = 1;
        while ((64'd1 << w) <= max_v) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + digit step with a digit-valid flag.
module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int W = 21
) (
    input  logic [W-1:0]           acc_in,
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [W-1:0]           acc_out,
    output logic                   digit_ok
);

    // Multiply by ten as (acc<<3)+(acc<<1) so no multiplier is inferred.
    always_comb begin
        acc_out  = (acc_in << 3) + (acc_in << 1) + {{(W-BCD_DIGIT_W){1'b0}}, digit};
        digit_ok = (digit <= BCD_DIGIT_MAX);
    end

endmodule

// File: rtl/bcd6_to_bin.sv
// Iterative packed-BCD to binary converter, one digit per clock, MSD first.
// Optional invalid-digit checking is enabled with `define BCD2BIN_ERRCHK_EN.
module bcd6_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] BCD_IN,
    output logic [BIN_W-1:0]              BIN_OUT,
    output logic                          BUSY,
    output logic                          DONE,
    output logic                          ERR
);

    localparam int ACC_W = BIN_W + 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

    if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_width
        $error("BIN_W too small for DIGITS");
    end

    state_t                          state_q, state_d;
    logic [ACC_W-1:0]                acc_q, acc_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [BCD_DIGIT_W*DIGITS-1:0]   cap_q, cap_d;
    logic [BIN_W-1:0]                bin_q, bin_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            err_q, err_d;
    logic [BCD_DIGIT_W-1:0]          digit_s;
    logic [ACC_W-1:0]                mac_acc_s;
    logic                            digit_ok_s;

`ifdef BCD2BIN_ERRCHK_EN
    logic                            bad_q, bad_d;
`else
    logic                            unused_digit_ok_s;
    assign unused_digit_ok_s = digit_ok_s;
`endif

    assign digit_s = cap_q[{idx_q, 2'b00} +: BCD_DIGIT_W];

    bcd_mac10 #(.W(ACC_W)) u_mac (
        .acc_in   (acc_q),
        .digit    (digit_s),
        .acc_out  (mac_acc_s),
        .digit_ok (digit_ok_s)
    );

    // Next-state and datapath control for the IDLE/CONV sequencer.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        bin_d   = bin_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef BCD2BIN_ERRCHK_EN
        bad_d   = bad_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    cap_d   = BCD_IN;
                    acc_d   = '0;
                    idx_d   = IDX_TOP;
                    busy_d  = 1'b1;
                    state_d = ST_CONV;
`ifdef BCD2BIN_ERRCHK_EN
                    bad_d   = 1'b0;
`endif
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_CONV: begin
                acc_d = mac_acc_s;
`ifdef BCD2BIN_ERRCHK_EN
                bad_d = bad_q | ~digit_ok_s;
`endif
                if (idx_q == {IDX_W{1'b0}}) begin
                    idx_d   = {IDX_W{1'b0}};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
`ifdef BCD2BIN_ERRCHK_EN
                    if (bad_d) begin
                        bin_d = {BIN_W{1'b0}};
                        err_d = 1'b1;
                    end else begin
                        bin_d = mac_acc_s[BIN_W-1:0];
                        err_d = 1'b0;
                    end
`else
                    bin_d   = mac_acc_s[BIN_W-1:0];
                    err_d   = 1'b0;
`endif
                end else begin
                    idx_d   = idx_q - {{(IDX_W-1){1'b0}}, 1'b1};
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            cap_q   <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef BCD2BIN_ERRCHK_EN
            bad_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            bin_q   <= bin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef BCD2BIN_ERRCHK_EN
            bad_q   <= bad_d;
`endif
        end
    end

    assign BIN_OUT = bin_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_bcd6_to_bin.sv
// Scoreboard bench for bcd6_to_bin: stimulus pushes expectations, a DONE monitor pops and checks.
module tb_bcd6_to_bin;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [23:0] BCD_IN = 24'h0;
    logic [19:0] BIN_OUT;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int total = 0;
    int bad   = 0;
    logic [20:0] sb_q[$];

    bcd6_to_bin #(.DIGITS(6), .BIN_W(20)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .BCD_IN  (BCD_IN),
        .BIN_OUT (BIN_OUT),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every DONE must match the oldest pending expectation.
    always @(negedge CLK) begin
        if (!RST && DONE) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [20:0] e;
                e = sb_q.pop_front();
                chk("bin_out", {12'd0, BIN_OUT}, {12'd0, e[19:0]});
                chk("err", {31'd0, ERR}, {31'd0, e[20]});
            end
        end
    end

    // One conversion; optionally changes BCD_IN after capture and pokes START while busy.
    task automatic run_conv(input logic [23:0] bcd, input logic [23:0] later,
                            input bit poke, input logic [19:0] exp_bin, input logic exp_err);
        int lat;
        int busy_cnt;
        bit seen;
        lat = 0; busy_cnt = 0; seen = 1'b0;
        @(negedge CLK);
        sb_q.push_back({exp_err, exp_bin});
        BCD_IN = bcd;
        START  = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        BCD_IN = later;
        while (!seen && lat < 20) begin
            @(negedge CLK);
            lat++;
            if (poke && lat == 2) START = 1'b1;
            if (poke && lat == 3) START = 1'b0;
            if (DONE) begin
                seen = 1'b1;
                chk("busy_in_done_cycle", {31'd0, BUSY}, 32'd0);
            end else if (BUSY) begin
                busy_cnt++;
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("latency", lat, 32'd7);
        chk("busy_cycles", busy_cnt, 32'd6);
    endtask

    initial begin
        int ndone;
        int dcyc[4];

        RST = 1'b1;
        #12;
        chk("rst_bin", {12'd0, BIN_OUT}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_err", {31'd0, ERR}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        run_conv(24'h000000, 24'h000000, 1'b0, 20'd0, 1'b0);
        run_conv(24'h999999, 24'h999999, 1'b0, 20'hF423F, 1'b0);
        run_conv(24'h123456, 24'h123456, 1'b0, 20'h1E240, 1'b0);
        // Input changed after capture plus a START while busy.
        run_conv(24'h777777, 24'h111111, 1'b1, 20'd777777, 1'b0);
        repeat (10) @(negedge CLK);

        // START held for 20 edges: accepted at edges 0, 7, 14.
        ndone = 0;
        BCD_IN = 24'h000042;
        sb_q.push_back({1'b0, 20'd42});
        sb_q.push_back({1'b0, 20'd42});
        sb_q.push_back({1'b0, 20'd42});
        START = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge CLK);
            #1;
            if (c == 19) START = 1'b0;
            @(negedge CLK);
            if (DONE) begin
                if (ndone < 4) dcyc[ndone] = c;
                ndone++;
            end
        end
        chk("held_done_count", ndone, 32'd3);
        chk("held_first_done", dcyc[0], 32'd6);
        chk("held_spacing_1", dcyc[1] - dcyc[0], 32'd7);
        chk("held_spacing_2", dcyc[2] - dcyc[1], 32'd7);

`ifdef BCD2BIN_ERRCHK_EN
        run_conv(24'h00A001, 24'h00A001, 1'b0, 20'd0, 1'b1);
        run_conv(24'h000001, 24'h000001, 1'b0, 20'd1, 1'b0);
`else
        run_conv(24'h00A001, 24'h00A001, 1'b0, 20'd10001, 1'b0);
        run_conv(24'h000001, 24'h000001, 1'b0, 20'd1, 1'b0);
`endif

        // Asynchronous reset in the middle of a conversion.
        @(negedge CLK);
        BCD_IN = 24'h555555;
        START  = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, BUSY}, 32'd0);
        chk("mid_rst_done", {31'd0, DONE}, 32'd0);
        chk("mid_rst_bin", {12'd0, BIN_OUT}, 32'd0);
        chk("mid_rst_err", {31'd0, ERR}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (10) @(negedge CLK);
        chk("post_rst_idle", {31'd0, BUSY}, 32'd0);
        run_conv(24'h000315, 24'h000315, 1'b0, 20'd315, 1'b0);

        repeat (10) @(negedge CLK);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
